mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (F stage) and load/store (M stage).
- Runs a request/grant/response FSM toward memory and returns per-requester valid pulses.
- Produces stall requests that the hazard unit ORs into its StallF/StallD/StallE/StallM chain.
- Data side has priority. A bounded-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- IReqF  in  1  fetch request; held high until IValidF
- IAddrF  in  ADDR_W  fetch address; stable while IReqF is high
- FlushF  in  1  cancel the in-flight fetch (taken branch/jump)
- IRdataF  out  DATA_W  fetched instruction; valid only with IValidF
- IValidF  out  1  one-cycle fetch completion pulse
- DReqM  in  1  data request; held high until DValidM
- DWeM  in  1  1 = store, 0 = load
- DAddrM  in  ADDR_W  data address
- DWdataM  in  DATA_W  store data
- DBeM  in  DATA_W/8  store byte enables
- DRdataM  out  DATA_W  load data; valid only with DValidM
- DValidM  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  response/ack; exactly one per granted request, at earliest the cycle after mem_gnt
- mem_rdata  in  DATA_W  memory read data
- StallIMem  out  1  fetch side must stall
- StallDMem  out  1  memory stage must stall

Behaviour:
- FSM states: IDLE, REQ, RESP. Owner register: I or D. Drop flag: drop_q.
- Reset (asynchronous): state=IDLE, owner=D, drop_q=0, starve_cnt=0. All outputs 0; StallIMem/StallDMem follow the combinational rules below.
- IDLE arbitration:
  - DReqM wins unless IReqF=1 and starve_cnt==STARVE_MAX; then I wins.
  - On any grant decision go to REQ and latch owner, address, we, wdata and be into registers.
  - Fetches always drive mem_we=0 and mem_be=all-ones.
- REQ: mem_req=1 with the latched fields.
  - Fields and mem_req are held stable until mem_gnt.
  - mem_gnt=1 → RESP; mem_req drops in the next cycle.
- RESP: wait for mem_rvalid.
  - On mem_rvalid, pulse IValidF or DValidM for owner in the same cycle (combinational). IRdataF/DRdataM = mem_rdata.
  - Then go to IDLE. No back-to-back issue; minimum transaction length is 3 cycles (IDLE→REQ→RESP).
- starve_cnt (saturating, 4-bit):
  - Increments when D is granted while IReqF=1.
  - Clears when I is granted or when IReqF=0 in IDLE.
- Stalls (combinational):
  - StallIMem = IReqF & ~IValidF.
  - StallDMem = DReqM & ~DValidM.
- Flush:
  - FlushF=1 while owner=I in REQ or RESP sets drop_q. The request is not withdrawn; memory protocol forbids dropping mem_req before gnt.
  - The eventual mem_rvalid is consumed with IValidF=0, and the FSM returns to IDLE.
  - drop_q clears on that rvalid.
  - FlushF in IDLE, or while owner=D, has no effect.
  - The new fetch address is arbitrated normally after the drop completes.
- Simultaneous events:
  - FlushF in the same cycle as mem_rvalid for an I transaction suppresses IValidF.
  - DReqM and IReqF rising in the same IDLE cycle follow the arbitration rule above.
- Protocol errors: mem_rvalid outside RESP is ignored.
- Reset mid-transaction: FSM aborts to IDLE immediately. The memory model is reset by the same signal.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds two 32-bit output counters, wrapping, reset to 0:
  - perf_istall_cnt increments every cycle StallIMem=1.
  - perf_dstall_cnt increments every cycle StallDMem=1.
- When undefined, both ports still exist, tied to 0, and no counter flops are built.

Test Plan:
- Single load: DReqM=1, DWeM=0, DAddrM=0x100; memory grants in 1 cycle and rvalid 2 cycles later with 0xDEADBEEF → DValidM pulses once, DRdataM=0xDEADBEEF, StallDMem high until that cycle.
- Store: DWeM=1, DAddrM=0x200, DWdataM=0x12345678, DBeM=4'b0011 → mem_we=1, mem_be=0011, fields stable across 3 no-gnt cycles; DValidM on ack.
- Contention: IReqF and DReqM both held for 20 cycles, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I...
- Flush in flight: fetch 0x40 granted; FlushF pulses in RESP; rvalid returns 0x00000013 → IValidF stays 0. Next fetch 0x80 then completes with IValidF=1.
- Reset mid-RESP: assert reset while owner=D awaiting rvalid → mem_req=0, DValidM=0, state IDLE in the same cycle. A late rvalid after reset release is ignored.
- MEM_ARB_PERF_EN: a load with 5 stall cycles → perf_dstall_cnt=5 and perf_istall_cnt=0. Without the macro, both counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for the core's single memory port: instruction fetch versus load/store,
// data side first with bounded fetch starvation. Define MEM_ARB_PERF_EN to build the stall counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                IReqF,
    input  logic [ADDR_W-1:0]   IAddrF,
    input  logic                FlushF,
    output logic [DATA_W-1:0]   IRdataF,
    output logic                IValidF,
    input  logic                DReqM,
    input  logic                DWeM,
    input  logic [ADDR_W-1:0]   DAddrM,
    input  logic [DATA_W-1:0]   DWdataM,
    input  logic [DATA_W/8-1:0] DBeM,
    output logic [DATA_W-1:0]   DRdataM,
    output logic                DValidM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                StallIMem,
    output logic                StallDMem,
    output logic [31:0]         perf_istall_cnt,
    output logic [31:0]         perf_dstall_cnt
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} arbState_t;
    typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_t;

    arbState_t         state_r, stateNext_s;
    owner_t            owner_r, ownerNext_s;
    logic              drop_r, dropNext_s;
    logic [3:0]        starveCnt_r, starveCntNext_s;
    logic [ADDR_W-1:0] addr_r, addrNext_s;
    logic              we_r, weNext_s;
    logic [DATA_W-1:0] wdata_r, wdataNext_s;
    logic [BE_W-1:0]   be_r, beNext_s;
    logic              grantI_s, grantD_s, respDone_s, reqActive_s;

    // Arbitration, transaction sequencing, flush-drop tracking and starvation bookkeeping.
    always_comb begin
        stateNext_s     = state_r;
        ownerNext_s     = owner_r;
        dropNext_s      = drop_r;
        starveCntNext_s = starveCnt_r;
        addrNext_s      = addr_r;
        weNext_s        = we_r;
        wdataNext_s     = wdata_r;
        beNext_s        = be_r;
        grantI_s        = 1'b0;
        grantD_s        = 1'b0;
        respDone_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (DReqM && !(IReqF && (starveCnt_r == STARVE_LIM))) begin
                    grantD_s = 1'b1;
                end else if (IReqF) begin
                    grantI_s = 1'b1;
                end else begin
                    grantD_s = 1'b0;
                end
                if (grantD_s) begin
                    stateNext_s = REQ;
                    ownerNext_s = OWNER_D;
                    addrNext_s  = DAddrM;
                    weNext_s    = DWeM;
                    wdataNext_s = DWdataM;
                    beNext_s    = DBeM;
                end else if (grantI_s) begin
                    stateNext_s = REQ;
                    ownerNext_s = OWNER_I;
                    addrNext_s  = IAddrF;
                    weNext_s    = 1'b0;
                    wdataNext_s = {DATA_W{1'b0}};
                    beNext_s    = {BE_W{1'b1}};
                end else begin
                    stateNext_s = IDLE;
                end
                // Starvation pressure only builds while a fetch is actually waiting behind data.
                if (grantI_s || !IReqF) begin
                    starveCntNext_s = 4'd0;
                end else if (grantD_s && (starveCnt_r != 4'hF)) begin
                    starveCntNext_s = starveCnt_r + 4'd1;
                end else begin
                    starveCntNext_s = starveCnt_r;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    stateNext_s = RESP;
                end else begin
                    stateNext_s = REQ;
                end
                if ((owner_r == OWNER_I) && FlushF) begin
                    dropNext_s = 1'b1;
                end else begin
                    dropNext_s = drop_r;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    stateNext_s = IDLE;
                    respDone_s  = 1'b1;
                    dropNext_s  = 1'b0;
                end else if ((owner_r == OWNER_I) && FlushF) begin
                    dropNext_s = 1'b1;
                end else begin
                    dropNext_s = drop_r;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // Arbiter state and latched request fields; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= OWNER_D;
            drop_r      <= 1'b0;
            starveCnt_r <= 4'd0;
            addr_r      <= {ADDR_W{1'b0}};
            we_r        <= 1'b0;
            wdata_r     <= {DATA_W{1'b0}};
            be_r        <= {BE_W{1'b0}};
        end else begin
            state_r     <= stateNext_s;
            owner_r     <= ownerNext_s;
            drop_r      <= dropNext_s;
            starveCnt_r <= starveCntNext_s;
            addr_r      <= addrNext_s;
            we_r        <= weNext_s;
            wdata_r     <= wdataNext_s;
            be_r        <= beNext_s;
        end
    end

    // Memory fields are presented only while requesting so the idle bus stays quiet.
    assign reqActive_s = (state_r == REQ);
    assign mem_req     = reqActive_s;
    assign mem_we      = reqActive_s & we_r;
    assign mem_addr    = reqActive_s ? addr_r : {ADDR_W{1'b0}};
    assign mem_wdata   = reqActive_s ? wdata_r : {DATA_W{1'b0}};
    assign mem_be      = reqActive_s ? be_r : {BE_W{1'b0}};

    // A flush arriving with the response still kills the fetch completion.
    assign IValidF   = respDone_s & (owner_r == OWNER_I) & ~drop_r & ~FlushF;
    assign DValidM   = respDone_s & (owner_r == OWNER_D);
    assign IRdataF   = IValidF ? mem_rdata : {DATA_W{1'b0}};
    assign DRdataM   = DValidM ? mem_rdata : {DATA_W{1'b0}};
    assign StallIMem = IReqF & ~IValidF;
    assign StallDMem = DReqM & ~DValidM;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perfIStall_r, perfDStall_r;

    // Stall-cycle counters, free running and wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perfIStall_r <= 32'd0;
            perfDStall_r <= 32'd0;
        end else begin
            perfIStall_r <= StallIMem ? (perfIStall_r + 32'd1) : perfIStall_r;
            perfDStall_r <= StallDMem ? (perfDStall_r + 32'd1) : perfDStall_r;
        end
    end

    assign perf_istall_cnt = perfIStall_r;
    assign perf_dstall_cnt = perfDStall_r;
`else
    assign perf_istall_cnt = 32'd0;
    assign perf_dstall_cnt = 32'd0;
`endif

endmodule
